// File: rtl/wb_cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_cdb_pkg
// Shared definitions for the completion-bus (CDB) write-back arbiter:
//   - default tag / data widths
//   - requester index constants (ALU0..ALU2, LSQ load return)
//   - wb_pkt_t, the packed {tag, data, pc} result packet
//   - wrap_idx(), a modulo helper for the round-robin scan
// -----------------------------------------------------------------------------
package wb_cdb_pkg;

    localparam int TAG_W_DEF  = 6;
    localparam int DATA_W_DEF = 32;

    localparam int REQ_ALU0 = 0;
    localparam int REQ_ALU1 = 1;
    localparam int REQ_ALU2 = 2;
    localparam int REQ_LSQ  = 3;

    typedef struct packed {
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] data;
        logic [DATA_W_DEF-1:0] pc;
    } wb_pkt_t;

    // Single-step wrap; the scan offset never exceeds 2*n-1.
    function automatic int wrap_idx(input int i, input int n);
        return (i >= n) ? (i - n) : i;
    endfunction

endpackage

// File: rtl/wb_cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_cdb_arbiter_if
// Bundles the producer-side request handshake and the completion broadcast
// ports of wb_cdb_arbiter.
//   slave  : arbiter side (consumes req_*, drives req_ready and cdb_*)
//   master : producer / consumer side (drives req_*, observes the rest)
// Per-requester and per-port fields are flattened; index i lives in slice i.
// -----------------------------------------------------------------------------
interface wb_cdb_arbiter_if
    import wb_cdb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_PORT = 2,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*TAG_W-1:0]    req_tag;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ*DATA_W-1:0]   req_pc;

    logic [NUM_PORT-1:0]         cdb_valid;
    logic [NUM_PORT*TAG_W-1:0]   cdb_tag;
    logic [NUM_PORT*DATA_W-1:0]  cdb_data;
    logic [NUM_PORT*DATA_W-1:0]  cdb_pc;
    logic [NUM_PORT*2-1:0]       cdb_src;

    modport slave (
        input  req_valid, req_tag, req_data, req_pc,
        output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_pc, cdb_src
    );

    modport master (
        output req_valid, req_tag, req_data, req_pc,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_pc, cdb_src
    );
endinterface

// File: rtl/wb_req_fifo.sv
// -----------------------------------------------------------------------------
// wb_req_fifo
// Small per-requester result FIFO with combinational head (read from registered
// storage) so the arbiter can broadcast a packet the cycle after it is pushed.
// Ports:
//   clk, srst  clock, synchronous active-high reset
//   flush      empties the FIFO on the next edge
//   push, din  write din at tail (caller guarantees not full / not flushing)
//   pop        advance head (caller guarantees not empty)
//   count      occupancy, full, empty  status from registered state
//   head       packet at the head pointer
// -----------------------------------------------------------------------------
module wb_req_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 70
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic [W-1:0]                 head
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;

    // Storage carries no reset; validity is tracked purely by count_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count = count_reg;
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign head  = mem[head_reg];

endmodule

// File: rtl/wb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_cdb_arbiter
// Completion-bus scheduler: buffers result packets from NUM_REQ producers
// (ALU0..ALU2, LSQ) in per-requester FIFOs and grants up to NUM_PORT of them
// per cycle onto the broadcast ports, round-robin from rr_ptr.
// Ports:
//   clk        clock
//   rstn       synchronous reset, ACTIVE HIGH (in reset while rstn=1)
//   flush      drop every buffered packet on the next edge (rr_ptr kept)
//   bus        wb_cdb_arbiter_if.slave: req_valid/ready/tag/data/pc in,
//              cdb_valid/tag/data/pc/src out
//   stall_cnt  (only with WB_CDB_ARB_PERF_EN) per-requester saturating count
//              of cycles with req_valid=1 and req_ready=0
// Optional feature macro: WB_CDB_ARB_PERF_EN
// -----------------------------------------------------------------------------
module wb_cdb_arbiter
    import wb_cdb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_PORT  = 2,
    parameter int BUF_DEPTH = 2,
    parameter int TAG_W     = TAG_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    wb_cdb_arbiter_if.slave        bus
`ifdef WB_CDB_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]  stall_cnt
`endif
);
    localparam int PW    = TAG_W + 2*DATA_W;
    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SRC_W = 2;
    localparam int CNT_W = $clog2(BUF_DEPTH+1);

    logic [NUM_REQ-1:0] fifo_full;
    logic [NUM_REQ-1:0] fifo_empty;
    logic [NUM_REQ-1:0] fifo_push;
    logic [NUM_REQ-1:0] grant;
    logic [CNT_W-1:0]   fifo_count [NUM_REQ];
    logic [PW-1:0]      fifo_head  [NUM_REQ];

    logic [RR_W-1:0]    rr_ptr_reg;
    logic [RR_W-1:0]    rr_ptr_next;

    logic [NUM_PORT-1:0] port_valid;
    logic [PW-1:0]       port_pkt [NUM_PORT];
    logic [SRC_W-1:0]    port_src [NUM_PORT];

    // ------------------------------------------------------------------
    // Per-requester FIFOs
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            // Ready is registered occupancy only: a full FIFO refuses a push
            // even in a cycle where it is also being drained.
            assign bus.req_ready[gi] = (fifo_count[gi] != CNT_W'(BUF_DEPTH));
            assign fifo_push[gi]     = bus.req_valid[gi] & ~fifo_full[gi] & ~flush & ~rstn;

            wb_req_fifo #(
                .DEPTH (BUF_DEPTH),
                .W     (PW)
            ) u_fifo (
                .clk   (clk),
                .srst  (rstn),
                .flush (flush),
                .push  (fifo_push[gi]),
                .din   ({bus.req_tag[gi*TAG_W +: TAG_W],
                         bus.req_data[gi*DATA_W +: DATA_W],
                         bus.req_pc[gi*DATA_W +: DATA_W]}),
                .pop   (grant[gi]),
                .count (fifo_count[gi]),
                .full  (fifo_full[gi]),
                .empty (fifo_empty[gi]),
                .head  (fifo_head[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin scan: walk requesters from rr_ptr, the k-th non-empty
    // FIFO found drives port k. Nothing is granted while in reset so that
    // buffered packets are discarded rather than broadcast.
    // ------------------------------------------------------------------
    always_comb begin
        int n_grant;
        int idx;
        int last_idx;
        grant       = '0;
        port_valid  = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            port_pkt[p] = '0;
            port_src[p] = '0;
        end
        n_grant  = 0;
        idx      = 0;
        last_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = wrap_idx(int'(rr_ptr_reg) + k, NUM_REQ);
            if (!rstn && !fifo_empty[idx] && (n_grant < NUM_PORT)) begin
                grant[idx]          = 1'b1;
                port_valid[n_grant] = 1'b1;
                port_pkt[n_grant]   = fifo_head[idx];
                port_src[n_grant]   = SRC_W'(idx);
                last_idx            = idx;
                n_grant             = n_grant + 1;
            end
        end
        if (n_grant != 0) begin
            rr_ptr_next = RR_W'(wrap_idx(last_idx + 1, NUM_REQ));
        end else begin
            rr_ptr_next = rr_ptr_reg;
        end
    end

    // Flush leaves the pointer alone; reset returns it to requester 0.
    always_ff @(posedge clk) begin
        if (rstn) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // Broadcast port packing ({tag, data, pc} as stored in the FIFO)
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_PORT; gi++) begin : g_port
            assign bus.cdb_valid[gi]                 = port_valid[gi];
            assign bus.cdb_tag[gi*TAG_W +: TAG_W]    = port_pkt[gi][PW-1 -: TAG_W];
            assign bus.cdb_data[gi*DATA_W +: DATA_W] = port_pkt[gi][2*DATA_W-1 -: DATA_W];
            assign bus.cdb_pc[gi*DATA_W +: DATA_W]   = port_pkt[gi][DATA_W-1:0];
            assign bus.cdb_src[gi*SRC_W +: SRC_W]    = port_src[gi];
        end
    endgenerate

`ifdef WB_CDB_ARB_PERF_EN
    // ------------------------------------------------------------------
    // Stall counters: survive flush, cleared by reset, saturate at all-ones.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
            logic [31:0] stall_reg;
            always_ff @(posedge clk) begin
                if (rstn) begin
                    stall_reg <= '0;
                end else if (bus.req_valid[gi] && !bus.req_ready[gi] && (stall_reg != 32'hFFFF_FFFF)) begin
                    stall_reg <= stall_reg + 32'd1;
                end
            end
            assign stall_cnt[gi*32 +: 32] = stall_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_cdb_arbiter
// Self-checking bench: a queue-based model of the arbiter is compared against
// the DUT every cycle, with directed scenarios (reset, single push, contention,
// saturation, flush) carrying literal expectations, followed by random traffic.
// Inputs change just after the falling edge; outputs are checked 1 time unit
// later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_wb_cdb_arbiter;
    import wb_cdb_pkg::*;

    localparam int NR = 4;
    localparam int NP = 2;
    localparam int D  = 2;
    localparam int TW = 6;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rstn  = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    wb_cdb_arbiter_if #(.NUM_REQ(NR), .NUM_PORT(NP), .TAG_W(TW), .DATA_W(DW)) bus ();

`ifdef WB_CDB_ARB_PERF_EN
    logic [NR*32-1:0] stall_cnt;
`endif

    wb_cdb_arbiter #(
        .NUM_REQ   (NR),
        .NUM_PORT  (NP),
        .BUF_DEPTH (D),
        .TAG_W     (TW),
        .DATA_W    (DW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .bus       (bus.slave)
`ifdef WB_CDB_ARB_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Applied inputs and the values the next step() will apply
    logic [NR-1:0] in_valid = '0;
    logic [TW-1:0] in_tag  [NR];
    logic [DW-1:0] in_data [NR];
    logic [DW-1:0] in_pc   [NR];
    logic [TW-1:0] nx_tag  [NR];
    logic [DW-1:0] nx_data [NR];
    logic [DW-1:0] nx_pc   [NR];

    always_comb begin
        bus.req_valid = in_valid;
        for (int i = 0; i < NR; i++) begin
            bus.req_tag[i*TW +: TW]  = in_tag[i];
            bus.req_data[i*DW +: DW] = in_data[i];
            bus.req_pc[i*DW +: DW]   = in_pc[i];
        end
    end

    // Model state
    wb_pkt_t     mq [NR][$];
    int          m_rr;
    logic [31:0] m_stall [NR];
    int          accepted;
    int          seen;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare DUT outputs with the model for the current cycle, then advance
    // the model across the coming rising edge using the applied inputs.
    task automatic check_and_update();
        int          g[$];
        logic [NR-1:0] exp_ready;
        wb_pkt_t     pk;
        g = {};
        if (!rstn) begin
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (m_rr + k) % NR;
                if (mq[idx].size() > 0 && g.size() < NP) g.push_back(idx);
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (p < g.size()) begin
                pk = mq[g[p]][0];
                chk($sformatf("cdb_valid[%0d]", p), 64'(bus.cdb_valid[p]), 64'd1);
                chk($sformatf("cdb_tag[%0d]", p),   64'(bus.cdb_tag[p*TW +: TW]),  64'(pk.tag));
                chk($sformatf("cdb_data[%0d]", p),  64'(bus.cdb_data[p*DW +: DW]), 64'(pk.data));
                chk($sformatf("cdb_pc[%0d]", p),    64'(bus.cdb_pc[p*DW +: DW]),   64'(pk.pc));
                chk($sformatf("cdb_src[%0d]", p),   64'(bus.cdb_src[p*2 +: 2]),    64'(g[p]));
            end else begin
                chk($sformatf("cdb_idle[%0d]", p),
                    {bus.cdb_valid[p], bus.cdb_src[p*2 +: 2], bus.cdb_tag[p*TW +: TW],
                     bus.cdb_data[p*DW +: DW] | bus.cdb_pc[p*DW +: DW]}, 64'd0);
            end
        end
        for (int i = 0; i < NR; i++) exp_ready[i] = (mq[i].size() != D);
        chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
`ifdef WB_CDB_ARB_PERF_EN
        for (int i = 0; i < NR; i++)
            chk($sformatf("stall_cnt[%0d]", i), 64'(stall_cnt[i*32 +: 32]), 64'(m_stall[i]));
`endif
        seen += $countones(bus.cdb_valid);

        if (rstn) begin
            for (int i = 0; i < NR; i++) begin
                mq[i].delete();
                m_stall[i] = '0;
            end
            m_rr = 0;
        end else begin
            for (int i = 0; i < NR; i++)
                if (in_valid[i] && !exp_ready[i] && m_stall[i] != 32'hFFFF_FFFF) m_stall[i]++;
            foreach (g[p]) void'(mq[g[p]].pop_front());
            if (g.size() > 0) m_rr = (g[g.size()-1] + 1) % NR;
            if (flush) begin
                for (int i = 0; i < NR; i++) mq[i].delete();
            end else begin
                for (int i = 0; i < NR; i++) begin
                    if (in_valid[i] && exp_ready[i]) begin
                        pk.tag  = in_tag[i];
                        pk.data = in_data[i];
                        pk.pc   = in_pc[i];
                        mq[i].push_back(pk);
                        accepted++;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic f, input logic [NR-1:0] v);
        @(negedge clk);
        rstn     = r;
        flush    = f;
        in_valid = v;
        for (int i = 0; i < NR; i++) begin
            in_tag[i]  = nx_tag[i];
            in_data[i] = nx_data[i];
            in_pc[i]   = nx_pc[i];
        end
        #1;
        check_and_update();
    endtask

    task automatic set_pkt(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d, input logic [DW-1:0] p);
        nx_tag[i]  = t;
        nx_data[i] = d;
        nx_pc[i]   = p;
    endtask

    initial begin
        logic rdy_dropped;
        m_rr     = 0;
        accepted = 0;
        seen     = 0;
        for (int i = 0; i < NR; i++) begin
            set_pkt(i, TW'(i), 32'h0, 32'h0);
            in_tag[i]  = '0;
            in_data[i] = '0;
            in_pc[i]   = '0;
            m_stall[i] = '0;
        end

        // 1. Reset held with all valids asserted
        step(1'b1, 1'b0, 4'b1111);
        chk("reset_cdb_valid_0", 64'(bus.cdb_valid), 64'd0);
        step(1'b1, 1'b0, 4'b1111);
        chk("reset_cdb_valid_1", 64'(bus.cdb_valid), 64'd0);
        step(1'b0, 1'b0, 4'b0000);
        chk("post_reset_ready", 64'(bus.req_ready), 64'hF);
        chk("post_reset_idle", 64'(bus.cdb_valid), 64'd0);

        // 2. Single push on requester 1
        set_pkt(1, 6'd9, 32'hDEADBEEF, 32'h40);
        step(1'b0, 1'b0, 4'b0010);
        step(1'b0, 1'b0, 4'b0000);
        chk("single_valid", 64'(bus.cdb_valid), 64'b01);
        chk("single_tag",   64'(bus.cdb_tag[5:0]), 64'd9);
        chk("single_data",  64'(bus.cdb_data[31:0]), 64'hDEADBEEF);
        chk("single_pc",    64'(bus.cdb_pc[31:0]), 64'h40);
        chk("single_src",   64'(bus.cdb_src[1:0]), 64'd1);
        // rr_ptr is now 2: requesters 0 and 3 pending must come out 3 then 0
        set_pkt(0, 6'd1, 32'hA0, 32'h100);
        set_pkt(3, 6'd2, 32'hA3, 32'h104);
        step(1'b0, 1'b0, 4'b1001);
        step(1'b0, 1'b0, 4'b0000);
        chk("rr2_src0", 64'(bus.cdb_src[1:0]), 64'd3);
        chk("rr2_src1", 64'(bus.cdb_src[3:2]), 64'd0);

        // 3. Contention from rr_ptr=0
        step(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < NR; i++) set_pkt(i, TW'(10 + i), 32'h100 + i, 32'h200 + 4*i);
        step(1'b0, 1'b0, 4'b1111);
        step(1'b0, 1'b0, 4'b0000);
        chk("cont1_valid", 64'(bus.cdb_valid), 64'b11);
        chk("cont1_src",   64'(bus.cdb_src), 64'b01_00);
        chk("cont1_data0", 64'(bus.cdb_data[31:0]), 64'h100);
        step(1'b0, 1'b0, 4'b0000);
        chk("cont2_src",   64'(bus.cdb_src), 64'b11_10);
        chk("cont2_data1", 64'(bus.cdb_data[63:32]), 64'h103);
        step(1'b0, 1'b0, 4'b0000);
        chk("cont_drained", 64'(bus.cdb_valid), 64'd0);
        // rr_ptr back at 0: requesters 0 and 3 come out 0 then 3
        step(1'b0, 1'b0, 4'b1001);
        step(1'b0, 1'b0, 4'b0000);
        chk("rr0_src", 64'(bus.cdb_src), 64'b11_00);

        // 4. Saturation: all requesters valid for 10 cycles
        step(1'b1, 1'b0, 4'b0000);
        accepted    = 0;
        seen        = 0;
        rdy_dropped = 1'b0;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < NR; i++) set_pkt(i, TW'(c), (i << 16) | c, 32'h1000 + 4*c);
            step(1'b0, 1'b0, 4'b1111);
            if (c < 3 && bus.req_ready != 4'hF) rdy_dropped = 1'b1;
        end
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 4'b0000);
        chk("sat_ready_dropped", 64'(rdy_dropped), 64'd1);
        chk("sat_push_eq_bcast", 64'(seen), 64'(accepted));
        chk("sat_drained", 64'(bus.cdb_valid), 64'd0);

        // 5. Flush with 3 packets buffered
        step(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < NR; i++) set_pkt(i, TW'(20 + i), 32'hF00 + i, 32'h300);
        step(1'b0, 1'b0, 4'b0111);
        step(1'b0, 1'b1, 4'b1000);
        chk("flush_cycle_valid", 64'(bus.cdb_valid), 64'b11);
        step(1'b0, 1'b0, 4'b0000);
        chk("post_flush_valid", 64'(bus.cdb_valid), 64'd0);
        chk("post_flush_ready", 64'(bus.req_ready), 64'hF);
        step(1'b0, 1'b0, 4'b0000);
        chk("post_flush_gone", 64'(bus.cdb_valid), 64'd0);

        // 6. Random traffic with occasional flush and reset
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NR; i++) set_pkt(i, TW'($urandom), $urandom, $urandom);
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0), NR'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_cdb_arbiter.md
Name: wb_cdb_arbiter

Overview:
Completion-bus scheduler sitting between the execute/memory stages and the ROB/UIQ wakeup logic.
- Collects result packets from NUM_REQ producers: ALU0, ALU1, ALU2 and the LSQ load return.
- Buffers each producer's packets in a small per-requester FIFO.
- Grants up to NUM_PORT packets per cycle onto the completion broadcast ports, round-robin.
- The broadcast ports feed complete_pc_N / new_dr_data_N of the reorder buffer and the UIQ tag/value wakeup inputs.

Parameters:
- NUM_REQ, 4, number of requesters (index 0..2 = ALU0..2, 3 = LSQ).
- NUM_PORT, 2, broadcast ports per cycle (1..NUM_REQ).
- BUF_DEPTH, 2, entries per requester FIFO (power of two, >=2).
- TAG_W, 6, physical register tag width.
- DATA_W, 32, result and PC width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset, synchronous, active-high: the design is in reset when rstn=1.
- flush  in  1  squash all buffered results (mispredict recovery).
- req_valid  in  NUM_REQ  per-requester packet valid.
- req_ready  out  NUM_REQ  per-requester accept; equals buffer not full.
- req_tag  in  NUM_REQ*TAG_W  destination physical tag, requester i in slice i.
- req_data  in  NUM_REQ*DATA_W  result value.
- req_pc  in  NUM_REQ*DATA_W  instruction PC, used by the ROB to match the entry.
- cdb_valid  out  NUM_PORT  broadcast valid per port.
- cdb_tag  out  NUM_PORT*TAG_W  broadcast tag.
- cdb_data  out  NUM_PORT*DATA_W  broadcast value.
- cdb_pc  out  NUM_PORT*DATA_W  broadcast PC.
- cdb_src  out  NUM_PORT*2  requester index driving each port (debug/scoreboard).

Behaviour:
Push:
- A push occurs on the edge when req_valid[i] & req_ready[i] & ~flush & ~rstn.
- The packet is written at the FIFO tail and count[i] increments.
- req_ready[i] = (count[i] != BUF_DEPTH). It is computed from registered count only, so a full FIFO refuses a push even in a cycle where it pops.

Arbitration (combinational from registered state):
- Scan requesters starting at rr_ptr, ascending modulo NUM_REQ.
- The first NUM_PORT non-empty FIFOs are granted. The k-th grant in scan order drives port k with its FIFO head.
- Ports without a grant drive cdb_valid=0, and tag/data/pc/src=0.

Pop and pointer update:
- Every granted FIFO pops on the same edge; downstream has no backpressure.
- Latency: a packet pushed on the edge ending cycle t is broadcast in cycle t+1 at the earliest.
- rr_ptr <= (index of last grant + 1) mod NUM_REQ when any grant occurs; otherwise it holds.
- Simultaneous push and pop on the same FIFO: count is unchanged, and ordering within each requester is strict FIFO.

Flush:
- On the next edge, all counts, heads and tails go to 0.
- Pushes presented in the flush cycle are dropped.
- cdb outputs in the flush cycle still reflect the pre-flush state. From the next cycle, cdb_valid=0.
- rr_ptr is preserved.

Reset:
- rstn=1 dominates flush.
- Counts, heads, tails and rr_ptr go to 0.
- Resulting outputs: cdb_valid=0, cdb_tag/data/pc/src=0, req_ready all 1 after the reset edge.
- Reset asserted mid-operation discards all buffered packets without broadcasting them.

Invariants:
- No packet is duplicated or lost except by flush or reset.
- At most one port per requester per cycle.

Optional Feature:
WB_CDB_ARB_PERF_EN.
- When defined: adds output stall_cnt (NUM_REQ*32).
  - Counter i increments on every cycle with req_valid[i]=1 and req_ready[i]=0.
  - Counters saturate at 32'hFFFF_FFFF.
  - Reset clears them; flush does not.
- When undefined: the port and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package wb_cdb_pkg holds:
  - TAG_W and DATA_W defaults;
  - the requester index constants REQ_ALU0..REQ_ALU2 and REQ_LSQ;
  - the packed typedef wb_pkt_t {tag, data, pc}.
- Sub-module wb_req_fifo: one instance per requester, providing push, pop, flush, count, full, empty and head.
- The arbiter top holds the scan logic, rr_ptr and the optional counters.

Test Plan:
1. Reset: hold rstn=1 for 2 cycles with req_valid=4'b1111 → cdb_valid=2'b00 throughout; after release req_ready=4'b1111 and no packets are broadcast.
2. Single push: requester 1 pushes tag 6'd9, data 32'hDEADBEEF, pc 32'h40 at cycle t → in cycle t+1, cdb_valid=2'b01, port0 = {9, DEADBEEF, 40}, cdb_src[0]=1; rr_ptr becomes 2.
3. Contention: from rr_ptr=0, all 4 requesters push one packet in the same cycle →
   - next cycle: port0=req0, port1=req1;
   - following cycle: port0=req2, port1=req3;
   - then rr_ptr=0 and all FIFOs are empty.
4. Saturation: all 4 requesters hold req_valid=1 for 10 cycles with incrementing data →
   - req_ready deasserts for some requesters within 3 cycles;
   - the count of accepted pushes equals the count of broadcasts after draining;
   - per-requester data order is preserved;
   - no requester waits more than 2 consecutive grant cycles.
5. Flush: with 3 packets buffered, assert flush for one cycle → the next cycle shows cdb_valid=0, req_ready=4'b1111, and the buffered packets never appear.
6. Perf (macro defined): fill requester 2's FIFO and keep req_valid[2]=1 while it stays full for 5 cycles → stall_cnt[2]=5; a subsequent flush leaves it at 5.
